// File: rtl/led_scheduler.sv
// LED bank scheduler: round-robin time-sharing of one 8-bit LED bank between
// NSRC requesters. Each owner holds the bank for at most HOLD_TICKS ticks of
// the 100 Hz enable. Between owners the bank is blanked for at least one tick.
module led_scheduler #(
    parameter int NSRC       = 4,
    parameter int HOLD_TICKS = 50
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick_100Hz,
    input  logic [NSRC-1:0]   req,
    input  logic [8*NSRC-1:0] pat_bus,
    output logic [7:0]        LEDOut,
    output logic [NSRC-1:0]   grant,
    output logic              busy
);

    // Index width; kept at least one bit so a single-source build still elaborates.
    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
    // Hold count at which a pending tick ends the grant.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NSRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [NSRC-1:0] r_grant;
    logic [NSRC-1:0] w_grant_next;
    logic [IW-1:0]   r_idx;        // index of the current owner
    logic [IW-1:0]   w_idx_next;
    logic [IW-1:0]   r_last;       // index of the most recently released owner
    logic [IW-1:0]   w_last_next;
    logic [7:0]      r_hold;       // ticks spent in the current grant
    logic [7:0]      w_hold_next;
    logic [7:0]      r_led;
    logic [7:0]      w_led_next;
    logic            r_busy;
    logic            w_busy_next;

    logic [7:0]      w_pat [NSRC];
    logic            w_win_valid;
    logic [IW-1:0]   w_win_idx;
    logic            w_release;

    // Unpack the per-source pattern slices.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pat
            assign w_pat[gi] = pat_bus[8*gi +: 8];
        end
    endgenerate

    // Round-robin pick: the first requester found after r_last, wrapping.
    // Scanning from the farthest offset toward the nearest lets the nearest
    // requester overwrite, which gives it priority.
    always_comb begin
        logic [IW-1:0] w_cand;
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int off = NSRC; off >= 1; off--) begin
            w_cand = IW'((int'(r_last) + off) % NSRC);
            if (req[w_cand]) begin
                w_win_valid = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    // The grant ends on the last allowed tick or when the owner lets go.
    // If both happen on the same edge, this is still a single release.
    assign w_release = (tick_100Hz && (r_hold == HOLD_LAST)) || !req[r_idx];

    // Next-state and next-output logic for the IDLE / GRANT / GAP machine.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_idx_next   = r_idx;
        w_last_next  = r_last;
        w_hold_next  = r_hold;
        w_led_next   = r_led;
        case (r_state)
            ST_IDLE: begin
                w_grant_next = '0;
                w_led_next   = 8'h00;
                w_hold_next  = 8'h00;
                if (w_win_valid) begin
                    w_state_next = ST_GRANT;
                    w_idx_next   = w_win_idx;
                    w_grant_next = NSRC'(1) << w_win_idx;
                    // Load the pattern now so LEDOut is valid together with grant.
                    w_led_next   = w_pat[w_win_idx];
                end
            end
            ST_GRANT: begin
                w_led_next = w_pat[r_idx];
                if (w_release) begin
                    w_state_next = ST_GAP;
                    w_grant_next = '0;
                    w_led_next   = 8'h00;
                    w_hold_next  = 8'h00;
                    w_last_next  = r_idx;
                end else if (tick_100Hz) begin
                    w_hold_next = r_hold + 8'd1;
                end
            end
            ST_GAP: begin
                w_grant_next = '0;
                w_led_next   = 8'h00;
                w_hold_next  = 8'h00;
                if (tick_100Hz) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
                w_led_next   = 8'h00;
                w_hold_next  = 8'h00;
            end
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    // State and output registers. Reset overrides every transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_last  <= LAST_RST;
            r_hold  <= 8'h00;
            r_led   <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_idx   <= w_idx_next;
            r_last  <= w_last_next;
            r_hold  <= w_hold_next;
            r_led   <= w_led_next;
            r_busy  <= w_busy_next;
        end
    end

    assign LEDOut = r_led;
    assign grant  = r_grant;
    assign busy   = r_busy;

endmodule

// File: tb/tb_led_scheduler.sv
// Testbench for led_scheduler: a table of single-cycle vectors, followed by
// hand-written multi-cycle sequences for hold expiry, round robin, early
// release, the coincident tick/release case and HOLD_TICKS=1.
module tb_led_scheduler;

    localparam int TICK_DIV = 4;
    localparam logic [31:0] P0 = 32'hC35A_A511;
    localparam logic [31:0] P1 = 32'hC35A_A577;
    localparam logic [31:0] P2 = 32'hC35A_3C77;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick_100Hz;
    logic [3:0]  req;
    logic [3:0]  req1;
    logic [31:0] pat_bus;
    logic [7:0]  led;
    logic [7:0]  led1;
    logic [3:0]  grant;
    logic [3:0]  grant1;
    logic        busy;
    logic        busy1;

    always #5 clock = ~clock;

    led_scheduler #(.NSRC(4), .HOLD_TICKS(50)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick_100Hz (tick_100Hz),
        .req        (req),
        .pat_bus    (pat_bus),
        .LEDOut     (led),
        .grant      (grant),
        .busy       (busy)
    );

    led_scheduler #(.NSRC(4), .HOLD_TICKS(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .tick_100Hz (tick_100Hz),
        .req        (req1),
        .pat_bus    (pat_bus),
        .LEDOut     (led1),
        .grant      (grant1),
        .busy       (busy1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int tcnt  = 0;

    typedef struct {
        logic        rst;
        logic        tick;
        logic [3:0]  req;
        logic [31:0] pat;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_led;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pat_of(input logic [31:0] p, input int idx);
        return p[8*idx +: 8];
    endfunction

    // One edge with an explicit tick value; outputs are looked at 1 ns later.
    task automatic step_man(input logic t);
        tick_100Hz = t;
        @(posedge clock);
        #1;
    endtask

    // One edge with a free-running tick every TICK_DIV clocks.
    task automatic step_auto(output bit t);
        tick_100Hz = (tcnt == 0);
        t = tick_100Hz;
        tcnt = (tcnt + 1) % TICK_DIV;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_100Hz = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tcnt = 0;
    endtask

    function automatic vec_t mk(input logic r, input logic t, input logic [3:0] q,
                                input logic [31:0] p, input logic [3:0] g,
                                input logic [7:0] l, input logic b);
        vec_t v;
        v.rst = r; v.tick = t; v.req = q; v.pat = p;
        v.exp_grant = g; v.exp_led = l; v.exp_busy = b;
        return v;
    endfunction

    initial begin
        bit t;
        int n;
        int ticks;
        int gap_ticks;
        logic [3:0] rr_seq [5];

        reset = 1'b1;
        tick_100Hz = 1'b0;
        req = 4'b0000;
        req1 = 4'b0000;
        pat_bus = P0;

        // ---------------- table-driven single-cycle vectors ----------------
        vecs[0]  = mk(1'b1, 1'b1, 4'b1111, P0, 4'b0000, 8'h00, 1'b0); // reset wins over req/tick
        vecs[1]  = mk(1'b0, 1'b0, 4'b0000, P0, 4'b0000, 8'h00, 1'b0); // idle, nothing requested
        vecs[2]  = mk(1'b0, 1'b0, 4'b0101, P0, 4'b0001, 8'h11, 1'b1); // source 0 first after reset
        vecs[3]  = mk(1'b0, 1'b1, 4'b0101, P0, 4'b0001, 8'h11, 1'b1); // tick in GRANT, stays
        vecs[4]  = mk(1'b0, 1'b0, 4'b0101, P1, 4'b0001, 8'h77, 1'b1); // LEDOut follows pattern
        vecs[5]  = mk(1'b0, 1'b0, 4'b0100, P1, 4'b0000, 8'h00, 1'b1); // owner drops -> GAP
        vecs[6]  = mk(1'b0, 1'b0, 4'b0101, P1, 4'b0000, 8'h00, 1'b1); // GAP waits for tick
        vecs[7]  = mk(1'b0, 1'b1, 4'b0101, P1, 4'b0000, 8'h00, 1'b0); // tick -> IDLE
        vecs[8]  = mk(1'b0, 1'b0, 4'b0101, P1, 4'b0100, 8'h5A, 1'b1); // round robin skips 0 -> 2
        vecs[9]  = mk(1'b0, 1'b0, 4'b1111, P1, 4'b0100, 8'h5A, 1'b1); // other reqs ignored
        vecs[10] = mk(1'b0, 1'b0, 4'b1011, P1, 4'b0000, 8'h00, 1'b1); // source 2 drops -> GAP
        vecs[11] = mk(1'b0, 1'b1, 4'b0000, P1, 4'b0000, 8'h00, 1'b0); // tick -> IDLE
        vecs[12] = mk(1'b0, 1'b0, 4'b0000, P1, 4'b0000, 8'h00, 1'b0); // no memory of requests
        vecs[13] = mk(1'b0, 1'b0, 4'b1011, P1, 4'b1000, 8'hC3, 1'b1); // after 2 comes 3
        vecs[14] = mk(1'b1, 1'b0, 4'b1011, P1, 4'b0000, 8'h00, 1'b0); // reset mid-grant, no GAP
        vecs[15] = mk(1'b0, 1'b0, 4'b1110, P1, 4'b0010, 8'hA5, 1'b1); // last back to 3 -> source 1
        vecs[16] = mk(1'b0, 1'b0, 4'b1110, P2, 4'b0010, 8'h3C, 1'b1); // A5 -> 3C one cycle later
        vecs[17] = mk(1'b0, 1'b1, 4'b1110, P2, 4'b0010, 8'h3C, 1'b1); // tick while granted
        vecs[18] = mk(1'b1, 1'b0, 4'b1111, P2, 4'b0000, 8'h00, 1'b0); // reset during grant of 1
        vecs[19] = mk(1'b0, 1'b0, 4'b1111, P2, 4'b0001, 8'h77, 1'b1); // source 0 has priority

        for (int i = 0; i < 20; i++) begin
            reset      = vecs[i].rst;
            tick_100Hz = vecs[i].tick;
            req        = vecs[i].req;
            pat_bus    = vecs[i].pat;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            chk($sformatf("vec%0d_led", i),   32'(led),   32'(vecs[i].exp_led));
            chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].exp_busy));
            if (vecs[i].rst) begin
                chk($sformatf("vec%0d_hold", i), 32'(dut.r_hold), 32'd0);
            end
            $display("vec %0d: req=%b grant=%b led=%h busy=%b", i, req, grant, led, busy);
        end

        // ---------------- all four requesting: round robin, 50 ticks each ----------------
        do_reset();
        pat_bus = P0;
        req = 4'b1111;
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            gap_ticks = 0;
            while (grant == 4'b0000 && n < 400) begin
                step_auto(t);
                if (t) gap_ticks++;
                n++;
            end
            chk($sformatf("rr%0d_wait", g), 32'(n < 400), 32'd1);
            chk($sformatf("rr%0d_grant", g), 32'(grant), 32'(rr_seq[g]));
            chk($sformatf("rr%0d_led", g), 32'(led), 32'(pat_of(P0, $clog2(rr_seq[g]))));
            if (g > 0) begin
                chk($sformatf("rr%0d_gap_ticks", g), 32'(gap_ticks), 32'd1);
            end
            n = 0;
            ticks = 0;
            while (grant != 4'b0000 && n < 400) begin
                step_auto(t);
                if (t) ticks++;
                n++;
            end
            chk($sformatf("rr%0d_hold_ticks", g), 32'(ticks), 32'd50);
            chk($sformatf("rr%0d_gap_led", g), 32'(led), 32'd0);
            chk($sformatf("rr%0d_gap_busy", g), 32'(busy), 32'd1);
            $display("rr grant %0d: grant=%b held %0d ticks, gap %0d ticks", g, rr_seq[g], ticks, gap_ticks);
        end

        // ---------------- source 2 releases early after 7 ticks ----------------
        do_reset();
        req = 4'b0100;
        step_man(1'b0);
        chk("early_grant", 32'(grant), 32'b0100);
        req = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            step_man(1'b1);
            step_man(1'b0);
        end
        chk("early_still", 32'(grant), 32'b0100);
        chk("early_hold7", 32'(dut.r_hold), 32'd7);
        req = 4'b1011;
        step_man(1'b0);
        chk("early_gap_grant", 32'(grant), 32'd0);
        chk("early_gap_led", 32'(led), 32'd0);
        chk("early_gap_busy", 32'(busy), 32'd1);
        chk("early_gap_hold", 32'(dut.r_hold), 32'd0);
        step_man(1'b1);
        chk("early_idle_busy", 32'(busy), 32'd0);
        step_man(1'b0);
        chk("early_next_grant", 32'(grant), 32'b1000);
        $display("early release: next grant=%b", grant);

        // ---------------- tick at count 49 coincides with req drop ----------------
        do_reset();
        req = 4'b0010;
        step_man(1'b0);
        chk("coinc_grant", 32'(grant), 32'b0010);
        for (int k = 0; k < 49; k++) begin
            step_man(1'b1);
            step_man(1'b0);
        end
        chk("coinc_still", 32'(grant), 32'b0010);
        chk("coinc_hold49", 32'(dut.r_hold), 32'd49);
        req = 4'b0101;
        step_man(1'b1);
        chk("coinc_gap_grant", 32'(grant), 32'd0);
        chk("coinc_gap_busy", 32'(busy), 32'd1);
        step_man(1'b0);
        chk("coinc_gap_hold_busy", 32'(busy), 32'd1);
        step_man(1'b1);
        chk("coinc_idle_busy", 32'(busy), 32'd0);
        step_man(1'b0);
        chk("coinc_next_grant", 32'(grant), 32'b0100);
        $display("coincident release: next grant=%b", grant);

        // ---------------- HOLD_TICKS=1, single requester held ----------------
        do_reset();
        req = 4'b0000;
        req1 = 4'b0001;
        pat_bus = P0;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            gap_ticks = 0;
            while (grant1 == 4'b0000 && n < 100) begin
                step_auto(t);
                if (t) gap_ticks++;
                n++;
            end
            chk($sformatf("h1_%0d_grant", g), 32'(grant1), 32'b0001);
            chk($sformatf("h1_%0d_led", g), 32'(led1), 32'h11);
            if (g > 0) begin
                chk($sformatf("h1_%0d_gap_ticks", g), 32'(gap_ticks), 32'd1);
            end
            n = 0;
            ticks = 0;
            while (grant1 != 4'b0000 && n < 100) begin
                step_auto(t);
                if (t) ticks++;
                n++;
            end
            chk($sformatf("h1_%0d_hold_ticks", g), 32'(ticks), 32'd1);
            chk($sformatf("h1_%0d_gap_busy", g), 32'(busy1), 32'd1);
            $display("hold1 round %0d: held %0d ticks, gap %0d ticks", g, ticks, gap_ticks);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
